// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port arbiter bus: requester-side fields in, arbitrated port out.
// The data-width package lives here so it is compiled ahead of every user.

package pkg_en;
   localparam int WIDTH_DATA = 8;
endpackage

interface mem_port_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH_ADDR = 8,
   parameter int WIDTH_DATA = pkg_en::WIDTH_DATA
);
   // Requester side, packed per requester
   logic [NUM_REQ-1:0]            I_Req;
   logic [NUM_REQ-1:0]            I_We;
   logic [2*NUM_REQ-1:0]          I_AccessMode;
   logic [WIDTH_ADDR*NUM_REQ-1:0] I_Address;
   logic [WIDTH_DATA*NUM_REQ-1:0] I_Data;
   logic [NUM_REQ-1:0]            I_End;
   logic [NUM_REQ-1:0]            O_Grant;

   // Memory port side
   logic                          O_Req;
   logic                          O_We;
   logic [1:0]                    O_AccessMode;
   logic [WIDTH_ADDR-1:0]         O_Address;
   logic [WIDTH_DATA-1:0]         O_Data;
   logic [WIDTH_DATA-1:0]         I_Rd_Data;

   // Read return and status
   logic [NUM_REQ-1:0]            O_Rd_Valid;
   logic [WIDTH_DATA-1:0]         O_Rd_Data;
   logic                          O_Busy;

   // Arbiter view
   modport slave (
      input  I_Req, I_We, I_AccessMode, I_Address, I_Data, I_End, I_Rd_Data,
      output O_Grant, O_Req, O_We, O_AccessMode, O_Address, O_Data,
             O_Rd_Valid, O_Rd_Data, O_Busy
   );

   // Requester / memory environment view
   modport master (
      output I_Req, I_We, I_AccessMode, I_Address, I_Data, I_End, I_Rd_Data,
      input  O_Grant, O_Req, O_We, O_AccessMode, O_Address, O_Data,
             O_Rd_Valid, O_Rd_Data, O_Busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter giving NUM_REQ load/store requesters exclusive bursts
// on one memory port. A grant is held until the owner signals I_End, or is
// preempted after MAX_HOLD cycles when someone else is waiting. Every grant
// is separated from the next by one IDLE cycle.

module mem_port_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH_ADDR = 8,
   parameter int MAX_HOLD   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   mem_port_arbiter_if.slave    bus
);

   localparam int WIDTH_DATA = pkg_en::WIDTH_DATA;
   localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W      = $clog2(MAX_HOLD) + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   // One-hot vector for a requester index
   function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PTR_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
      return vec;
   endfunction

   // Next requester index, wrapping NUM_REQ-1 back to 0
   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
      logic [PTR_W-1:0] nxt;
      if (idx == PTR_W'(NUM_REQ - 1)) begin
         nxt = {PTR_W{1'b0}};
      end else begin
         nxt = idx + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

   logic [0:0]             state_r;
   logic [PTR_W-1:0]       ptr_r;
   logic [PTR_W-1:0]       owner_r;
   logic [CNT_W-1:0]       hold_cnt_r;
   logic [NUM_REQ-1:0]     grant_r;
   logic [NUM_REQ-1:0]     rd_valid_r;

   logic                   pick_found_s;
   logic [PTR_W-1:0]       pick_idx_s;
   logic [PTR_W-1:0]       scan_idx_s;

   logic                   owner_end_s;
   logic                   others_req_s;
   logic                   preempt_s;
   logic                   release_s;

   logic                   port_req_s;
   logic                   port_we_s;
   logic [1:0]             port_mode_s;
   logic [WIDTH_ADDR-1:0]  port_addr_s;
   logic [WIDTH_DATA-1:0]  port_data_s;

   // Search for the first requester starting at the rotating pointer
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = {PTR_W{1'b0}};
      scan_idx_s   = ptr_r;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found_s && bus.I_Req[scan_idx_s]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = scan_idx_s;
         end else begin
            pick_found_s = pick_found_s;
         end
         scan_idx_s = next_idx(scan_idx_s);
      end
   end

   // Release on the owner's last access, or preempt when the hold budget is spent and others wait
   always_comb begin
      owner_end_s  = bus.I_Req[owner_r] & bus.I_End[owner_r];
      others_req_s = |(bus.I_Req & ~to_onehot(owner_r));
      preempt_s    = (hold_cnt_r == CNT_W'(MAX_HOLD - 1)) & others_req_s;
      if (state_r == ST_OWN) begin
         release_s = owner_end_s | preempt_s;
      end else begin
         release_s = 1'b0;
      end
   end

   // Memory port follows the owner's fields while a grant is held, otherwise quiet
   always_comb begin
      port_req_s  = 1'b0;
      port_we_s   = 1'b0;
      port_mode_s = 2'b00;
      port_addr_s = {WIDTH_ADDR{1'b0}};
      port_data_s = {WIDTH_DATA{1'b0}};
      if (state_r == ST_OWN) begin
         port_req_s  = bus.I_Req[owner_r];
         port_we_s   = bus.I_We[owner_r];
         port_mode_s = bus.I_AccessMode[int'(owner_r)*2 +: 2];
         port_addr_s = bus.I_Address[int'(owner_r)*WIDTH_ADDR +: WIDTH_ADDR];
         port_data_s = bus.I_Data[int'(owner_r)*WIDTH_DATA +: WIDTH_DATA];
      end else begin
         port_req_s  = 1'b0;
      end
   end

   // Arbitration FSM: grant from IDLE, hold/count in OWN, rotate pointer on release
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         ptr_r      <= {PTR_W{1'b0}};
         owner_r    <= {PTR_W{1'b0}};
         hold_cnt_r <= {CNT_W{1'b0}};
         grant_r    <= {NUM_REQ{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_found_s) begin
                  state_r    <= ST_OWN;
                  owner_r    <= pick_idx_s;
                  grant_r    <= to_onehot(pick_idx_s);
                  hold_cnt_r <= {CNT_W{1'b0}};
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_OWN: begin
               if (release_s) begin
                  state_r <= ST_IDLE;
                  grant_r <= {NUM_REQ{1'b0}};
                  ptr_r   <= next_idx(owner_r);
               end else if (hold_cnt_r < CNT_W'(MAX_HOLD)) begin
                  hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  hold_cnt_r <= hold_cnt_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               grant_r <= {NUM_REQ{1'b0}};
            end
         endcase
      end
   end

   // Read data returns one cycle after a load; tag it with the owner that issued it
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_valid_r <= {NUM_REQ{1'b0}};
      end else if (port_req_s && !port_we_s) begin
         rd_valid_r <= to_onehot(owner_r);
      end else begin
         rd_valid_r <= {NUM_REQ{1'b0}};
      end
   end

   assign bus.O_Grant      = grant_r;
   assign bus.O_Busy       = (state_r == ST_OWN);
   assign bus.O_Req        = port_req_s;
   assign bus.O_We         = port_we_s;
   assign bus.O_AccessMode = port_mode_s;
   assign bus.O_Address    = port_addr_s;
   assign bus.O_Data       = port_data_s;
   assign bus.O_Rd_Valid   = rd_valid_r;
   assign bus.O_Rd_Data    = bus.I_Rd_Data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.

module tb_mem_port_arbiter;

   localparam int NR = 4;
   localparam int WA = 8;
   localparam int WD = pkg_en::WIDTH_DATA;
   localparam int MH = 16;

   logic clock;
   logic reset;
   int   checks_cnt;
   int   errors_cnt;
   int   own_cycles;

   mem_port_arbiter_if #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .WIDTH_DATA(WD)) bus ();

   mem_port_arbiter #(.NUM_REQ(NR), .WIDTH_ADDR(WA), .MAX_HOLD(MH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.I_Req        = '0;
      bus.I_We         = '0;
      bus.I_End        = '0;
      bus.I_AccessMode = '0;
      bus.I_Address    = '0;
      bus.I_Data       = '0;
      bus.I_Rd_Data    = '0;
   endtask

   task automatic drive_req(input int i, input logic req, input logic we, input logic en,
                            input logic [1:0] mode, input logic [7:0] addr, input logic [7:0] data);
      bus.I_Req[i]              = req;
      bus.I_We[i]               = we;
      bus.I_End[i]              = en;
      bus.I_AccessMode[2*i +: 2] = mode;
      bus.I_Address[i*WA +: WA] = addr;
      bus.I_Data[i*WD +: WD]    = data;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      clear_inputs();
      reset = 1'b0;
      #12;
      // reset state
      check_val("rst_grant", 32'(bus.O_Grant), 32'h0);
      check_val("rst_busy", 32'(bus.O_Busy), 32'h0);
      check_val("rst_req", 32'(bus.O_Req), 32'h0);
      check_val("rst_we", 32'(bus.O_We), 32'h0);
      check_val("rst_rdv", 32'(bus.O_Rd_Valid), 32'h0);
      reset = 1'b1;
      tick();

      // pointer starts at 0: 1010 grants requester 1, then 3 two cycles after the end
      drive_req(1, 1'b1, 1'b1, 1'b0, 2'b01, 8'h11, 8'h22);
      drive_req(3, 1'b1, 1'b1, 1'b0, 2'b10, 8'h33, 8'h44);
      #1;
      check_val("idle_req_zero", 32'(bus.O_Req), 32'h0);
      check_val("idle_addr_zero", 32'(bus.O_Address), 32'h0);
      tick();
      check_val("g1_grant", 32'(bus.O_Grant), 32'h2);
      check_val("g1_busy", 32'(bus.O_Busy), 32'h1);
      check_val("g1_addr", 32'(bus.O_Address), 32'h11);
      check_val("g1_data", 32'(bus.O_Data), 32'h22);
      check_val("g1_mode", 32'(bus.O_AccessMode), 32'h1);
      bus.I_End[1] = 1'b1;
      tick();
      check_val("g1_rel_grant", 32'(bus.O_Grant), 32'h0);
      check_val("g1_rel_busy", 32'(bus.O_Busy), 32'h0);
      drive_req(1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      tick();
      check_val("g3_grant", 32'(bus.O_Grant), 32'h8);
      check_val("g3_addr", 32'(bus.O_Address), 32'h33);
      bus.I_End[3] = 1'b1;
      tick();
      check_val("g3_rel_grant", 32'(bus.O_Grant), 32'h0);

      // all request with I_End every access: 0,1,2,3,0 with idle gaps
      for (int i = 0; i < NR; i++) begin
         drive_req(i, 1'b1, 1'b0, 1'b1, 2'b00, 8'(i), 8'h00);
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val($sformatf("rr_grant_%0d", k), 32'(bus.O_Grant), 32'h1 << (k % 4));
         tick();
         check_val($sformatf("rr_gap_%0d", k), 32'(bus.O_Grant), 32'h0);
      end
      clear_inputs();

      // lone owner keeps the grant with I_Req low (pointer now 1, so 2 wins)
      drive_req(2, 1'b1, 1'b0, 1'b0, 2'b00, 8'h20, 8'h00);
      tick();
      check_val("hold_grant0", 32'(bus.O_Grant), 32'h4);
      bus.I_Req[2] = 1'b0;
      repeat (20) tick();
      check_val("hold_grant20", 32'(bus.O_Grant), 32'h4);
      check_val("hold_busy20", 32'(bus.O_Busy), 32'h1);
      check_val("hold_oreq_low", 32'(bus.O_Req), 32'h0);
      bus.I_End[2] = 1'b1;
      tick();
      check_val("end_wo_req", 32'(bus.O_Grant), 32'h4);
      bus.I_Req[2] = 1'b1;
      tick();
      check_val("hold_rel", 32'(bus.O_Grant), 32'h0);
      clear_inputs();

      // preemption: owner 0 without I_End, requester 2 waiting -> 16 OWN cycles
      drive_req(0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h05, 8'h00);
      tick();
      check_val("pre_grant0", 32'(bus.O_Grant), 32'h1);
      drive_req(2, 1'b1, 1'b0, 1'b0, 2'b00, 8'h06, 8'h00);
      own_cycles = 0;
      while (bus.O_Grant == 4'b0001 && own_cycles < 40) begin
         own_cycles++;
         tick();
      end
      check_val("pre_own_cycles", 32'(own_cycles), 32'd16);
      check_val("pre_gap", 32'(bus.O_Grant), 32'h0);
      tick();
      check_val("pre_grant2", 32'(bus.O_Grant), 32'h4);
      bus.I_Req[0] = 1'b0;
      bus.I_End[2] = 1'b1;
      tick();
      clear_inputs();

      // load from owner 1 in its release cycle, then a store
      drive_req(1, 1'b1, 1'b0, 1'b0, 2'b11, 8'h3C, 8'h00);
      tick();
      check_val("ld_grant", 32'(bus.O_Grant), 32'h2);
      bus.I_End[1] = 1'b1;
      #1;
      check_val("ld_oreq", 32'(bus.O_Req), 32'h1);
      check_val("ld_owe", 32'(bus.O_We), 32'h0);
      check_val("ld_addr", 32'(bus.O_Address), 32'h3C);
      tick();
      clear_inputs();
      bus.I_Rd_Data = 8'hA5;
      drive_req(1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h40, 8'h5A);
      #1;
      check_val("ld_rdvalid", 32'(bus.O_Rd_Valid), 32'h2);
      check_val("ld_rddata", 32'(bus.O_Rd_Data), 32'hA5);
      check_val("ld_rel_grant", 32'(bus.O_Grant), 32'h0);
      tick();
      check_val("st_grant", 32'(bus.O_Grant), 32'h2);
      check_val("st_rdv_idle", 32'(bus.O_Rd_Valid), 32'h0);
      check_val("st_owe", 32'(bus.O_We), 32'h1);
      check_val("st_data", 32'(bus.O_Data), 32'h5A);
      bus.I_End[1] = 1'b1;
      tick();
      check_val("st_no_rdv", 32'(bus.O_Rd_Valid), 32'h0);
      clear_inputs();

      // reset mid-burst of requester 3, then arbitration restarts at 0
      drive_req(3, 1'b1, 1'b0, 1'b0, 2'b00, 8'h77, 8'h00);
      tick();
      check_val("rb_grant3", 32'(bus.O_Grant), 32'h8);
      #1;
      check_val("rb_oreq", 32'(bus.O_Req), 32'h1);
      reset = 1'b0;
      #1;
      check_val("rb_grant_clr", 32'(bus.O_Grant), 32'h0);
      check_val("rb_oreq_clr", 32'(bus.O_Req), 32'h0);
      check_val("rb_busy_clr", 32'(bus.O_Busy), 32'h0);
      drive_req(0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h01, 8'h00);
      reset = 1'b1;
      tick();
      check_val("rb_grant0", 32'(bus.O_Grant), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one memory port (load/store units).
REQ-002 The block SHALL have parameter WIDTH_ADDR, default 8, giving the memory address width; data width SHALL be pkg_en::WIDTH_DATA.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum number of cycles one grant is held while other requests wait.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 I_Req  input  NUM_REQ  per-requester access request, one access per cycle.
REQ-007 I_We  input  NUM_REQ  per-requester 1 = store, 0 = load.
REQ-008 I_AccessMode  input  2*NUM_REQ  packed access mode; requester i at bits [2i+1:2i].
REQ-009 I_Address  input  WIDTH_ADDR*NUM_REQ  packed address; requester i at slice i.
REQ-010 I_Data  input  WIDTH_DATA*NUM_REQ  packed store data; requester i at slice i.
REQ-011 I_End  input  NUM_REQ  last access of burst; valid only with I_Req.
REQ-012 O_Grant  output  NUM_REQ  registered one-hot grant.
REQ-013 O_Req, O_We  output  1 each  memory port request and write enable.
REQ-014 O_AccessMode  output  2; O_Address  output  WIDTH_ADDR; O_Data  output  WIDTH_DATA  memory port fields.
REQ-015 I_Rd_Data  input  WIDTH_DATA  memory read data, one cycle after a load.
REQ-016 O_Rd_Valid  output  NUM_REQ  one-hot read-data valid; O_Rd_Data  output  WIDTH_DATA  read data.
REQ-017 O_Busy  output  1  high when any grant is held.

Function
REQ-018 The FSM SHALL have states IDLE and OWN; O_Busy SHALL be 1 exactly in OWN.
REQ-019 In IDLE with any I_Req high, the block SHALL select the first requesting index searching Ptr, Ptr+1, ... modulo NUM_REQ, register it as Owner, and enter OWN with O_Grant[Owner]=1 on the next cycle.
REQ-020 Grant latency SHALL be exactly 1 cycle from a request seen in IDLE to O_Grant.
REQ-021 In OWN, port outputs SHALL be a combinational mux of Owner's inputs: O_Req=I_Req[Owner], O_We=I_We[Owner], plus its AccessMode, Address and Data.
REQ-022 In IDLE, O_Req and O_We SHALL be 0; O_AccessMode, O_Address and O_Data SHALL be 0.
REQ-023 Hold counter (width $clog2(MAX_HOLD)+1) SHALL clear on grant and increment every cycle in OWN, saturating at MAX_HOLD.
REQ-024 Release SHALL occur at the end of the OWN cycle in which either I_Req[Owner]&I_End[Owner] is high, or the counter equals MAX_HOLD-1 while any non-owner I_Req is high (preemption).
REQ-025 On release, the FSM SHALL go to IDLE, O_Grant SHALL clear, and Ptr SHALL become Owner+1, wrapping NUM_REQ-1 to 0.
REQ-026 The minimum gap between successive grants SHALL be one IDLE cycle, including back-to-back bursts by the same requester.
REQ-027 The access issued in the release cycle SHALL still be performed; a preempted requester SHALL re-request to continue.
REQ-028 With no other requests pending, the owner SHALL keep the grant indefinitely until I_End, even with I_Req[Owner]=0.
REQ-029 I_End without I_Req SHALL be ignored; requests from non-owners in OWN SHALL be ignored and not latched.
REQ-030 O_Rd_Valid SHALL be the registered one-hot of Owner, gated by (O_Req & ~O_We) of the previous cycle; it remains valid even if the grant was released in that cycle.
REQ-031 O_Rd_Data SHALL equal I_Rd_Data combinationally.

Reset
REQ-032 On reset=0, asynchronously: state IDLE, Ptr=0, Owner=0, counter=0, O_Grant=0, O_Rd_Valid=0, O_Busy=0, O_Req=0, O_We=0.
REQ-033 Reset asserted mid-burst SHALL drop O_Req and O_Grant immediately; the first arbitration after release SHALL start from index 0.

Verification
REQ-034 I_Req=4'b1010 in IDLE after reset -> O_Grant=4'b0010 next cycle; after I_End, grant 4'b1000 is asserted 2 cycles after the end cycle.
REQ-035 All four requesters request continuously with I_End on every access -> grants rotate 0,1,2,3,0, one idle cycle between each.
REQ-036 Requester 0 holds the grant with no I_End while requester 2 requests, MAX_HOLD=16 -> release after 16 OWN cycles, then O_Grant=4'b0100.
REQ-037 Owner 1 issues a load to address 0x3C, I_Rd_Data=0xA5 next cycle -> O_Rd_Valid=4'b0010, O_Rd_Data=0xA5; a store raises no O_Rd_Valid.
REQ-038 reset pulsed low during an OWN burst of requester 3 -> O_Grant=0 and O_Req=0 immediately; a later I_Req=4'b1001 grants requester 0.
